fetch_decode_queue: RTL and testbench

- Parametrised instruction buffer between fetch_stage and decode_stage. Generalises the fixed 2-wide fetch-to-decode hand-off to WIDTH lanes.
- Absorbs fetch/decode rate mismatch, compacts sparse fetch groups in lane order, and presents the oldest WIDTH instructions to decode.
- Supports partial consumption by decode and single-cycle flush on redirect.

---
 rtl/fetch_decode_queue.sv | 111 +++++++++++
 tb/tb_fetch_decode_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: compacts sparse fetch groups,
// keeps program order across pointer wrap, and presents the oldest WIDTH
// entries to decode. Decode may consume fewer than WIDTH per cycle.
module fetch_decode_queue #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             i_valid,
  input  logic [WIDTH*DATA_W-1:0]      i_instr,
  input  logic [WIDTH*PC_W-1:0]        i_pc,
  output logic                         i_ready,
  output logic [WIDTH-1:0]             o_valid,
  output logic [WIDTH*DATA_W-1:0]      o_instr,
  output logic [WIDTH*PC_W-1:0]        o_pc,
  input  logic [$clog2(WIDTH+1)-1:0]   i_deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int DCNT_W = $clog2(WIDTH+1);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              enq;
  logic [DCNT_W-1:0] enq_n;
  logic [CNT_W-1:0]  eff;
  logic [CNT_W:0]    count_sum;
  logic [CNT_W-1:0]  count_next;

  // Number of valid lanes strictly below lane n; this is the compacted
  // write offset of lane n relative to tail.
  function automatic logic [DCNT_W-1:0] lanes_below(input logic [WIDTH-1:0] v,
                                                    input int n);
    logic [DCNT_W-1:0] c;
    c = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < n && v[j]) c = c + DCNT_W'(1);
    end
    return c;
  endfunction

  // Acceptance, dequeue clamp and next occupancy, all from registered count.
  always_comb begin
    i_ready    = (count <= CNT_W'(DEPTH - WIDTH));
    enq        = reset && i_ready && (|i_valid) && !flush;
    enq_n      = enq ? lanes_below(i_valid, WIDTH) : '0;
    eff        = (CNT_W'(i_deq_cnt) < count) ? CNT_W'(i_deq_cnt) : count;
    count_sum  = {1'b0, count} + (CNT_W+1)'(enq_n) - {1'b0, eff};
    count_next = count_sum[CNT_W-1:0];
  end

  // Storage write: valid lanes land contiguously from tail in lane order.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (enq && i_valid[k]) begin
        instr_mem[tail + PTR_W'(lanes_below(i_valid, k))] <= i_instr[k*DATA_W +: DATA_W];
        pc_mem[tail + PTR_W'(lanes_below(i_valid, k))]    <= i_pc[k*PC_W +: PC_W];
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(eff);
      tail  <= tail + PTR_W'(enq_n);
      count <= count_next;
    end
  end

  // Occupancy can never exceed DEPTH because acceptance needs WIDTH free slots.
  always_ff @(posedge clk) begin
    if (reset && !flush) assert (count_sum <= (CNT_W+1)'(DEPTH));
  end

  // Decode view: oldest entries first, zero beyond occupancy.
  always_comb begin
    o_valid = '0;
    o_instr = '0;
    o_pc    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (count > CNT_W'(k)) begin
        o_valid[k]                  = 1'b1;
        o_instr[k*DATA_W +: DATA_W] = instr_mem[head + PTR_W'(k)];
        o_pc[k*PC_W +: PC_W]        = pc_mem[head + PTR_W'(k)];
      end
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: a queue-based reference model predicts the
// post-edge view for every driven cycle; a monitor compares it to the DUT.
module tb_fetch_decode_queue;

  localparam int WIDTH  = 2;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  i_valid = '0;
  logic [63:0] i_instr = '0;
  logic [63:0] i_pc = '0;
  logic        i_ready;
  logic [1:0]  o_valid;
  logic [63:0] o_instr;
  logic [63:0] o_pc;
  logic [1:0]  i_deq_cnt = '0;
  logic [3:0]  o_count;

  fetch_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc), .i_ready(i_ready),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .i_deq_cnt(i_deq_cnt), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct packed {
    logic [3:0]  cnt;
    logic [1:0]  vld;
    logic [63:0] ins;
    logic [63:0] pcs;
    logic        rdy;
  } snap_t;

  ent_t  mq[$];
  snap_t expq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [31:0] pc_ctr = 32'h100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and predict the state visible after the next rising edge.
  task automatic drive(input logic rn, input logic fl, input logic [1:0] v,
                       input logic [31:0] a0, input logic [31:0] p0,
                       input logic [31:0] a1, input logic [31:0] p1, input int deq);
    snap_t s;
    ent_t  e;
    int    eff;
    bit    acc;
    @(negedge clk);
    reset = rn; flush = fl; i_valid = v;
    i_instr = {a1, a0}; i_pc = {p1, p0}; i_deq_cnt = 2'(deq);
    if (!rn || fl) begin
      mq.delete();
    end else begin
      acc = (DEPTH - mq.size()) >= WIDTH;
      eff = (deq < mq.size()) ? deq : mq.size();
      repeat (eff) void'(mq.pop_front());
      if (acc) begin
        if (v[0]) begin e.instr = a0; e.pc = p0; mq.push_back(e); end
        if (v[1]) begin e.instr = a1; e.pc = p1; mq.push_back(e); end
      end
    end
    s.cnt = 4'(mq.size());
    s.vld = '0; s.ins = '0; s.pcs = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < mq.size()) begin
        s.vld[k]       = 1'b1;
        s.ins[k*32+:32] = mq[k].instr;
        s.pcs[k*32+:32] = mq[k].pc;
      end
    end
    s.rdy = (DEPTH - mq.size()) >= WIDTH;
    expq.push_back(s);
  endtask

  // Group with random instruction words and sequential PCs.
  task automatic grp(input logic [1:0] v, input int deq);
    drive(1'b1, 1'b0, v, $urandom, pc_ctr, $urandom, pc_ctr + 32'd4, deq);
    pc_ctr = pc_ctr + 32'd8;
  endtask

  task automatic idle(input int deq);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, deq);
  endtask

  // Monitor: compare the DUT view against each predicted snapshot.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("o_count", 64'(o_count), 64'(e.cnt));
        check("o_valid", 64'(o_valid), 64'(e.vld));
        check("o_instr", o_instr, e.ins);
        check("o_pc",    o_pc,    e.pcs);
        check("i_ready", 64'(i_ready), 64'(e.rdy));
      end
    end
  end

  initial begin
    // Reset state
    drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 2'b11, 32'hdead, 32'h1, 32'hbeef, 32'h2, 1);

    // Full group A/B, then drain
    drive(1'b1, 1'b0, 2'b11, 32'hAAAA_0000, 32'h100, 32'hBBBB_0000, 32'h104, 0);
    idle(2);

    // Sparse group: only lane1 valid
    drive(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'hCCCC_0000, 32'h208, 0);
    idle(1);

    // Fill to full, held group, refused single enqueue at count 7
    pc_ctr = 32'h100;
    repeat (4) grp(2'b11, 0);
    grp(2'b11, 0);
    idle(1);
    grp(2'b01, 0);

    // Flush with same-cycle enqueue and dequeue at count 5
    idle(2);
    drive(1'b1, 1'b1, 2'b11, 32'h1111, 32'h300, 32'h2222, 32'h304, 2);

    // Steady stream at count 4 across pointer wrap
    pc_ctr = 32'h100;
    grp(2'b11, 0);
    grp(2'b11, 0);
    repeat (20) grp(2'b11, 2);

    // Clamped dequeue from count 1
    idle(2);
    idle(2);
    grp(2'b01, 0);
    idle(2);

    // Reset in mid-stream at count 6 with traffic present
    repeat (3) grp(2'b11, 0);
    drive(1'b0, 1'b0, 2'b11, 32'h5555, 32'h400, 32'h6666, 32'h404, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 2));
    end

    idle(0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
